alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between the two issue slots of the
//            dual-issue pipeline. One slot is granted per cycle, with
//            round-robin on conflict. The ALU result is captured in a one-entry
//            output register. That register is tagged with the winning slot and
//            drained by writeback through a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s0_valid/s0_ready       slot 0 request handshake
//   s0_a, s0_b, s0_op       slot 0 operands and opcode
//   s1_*                    same as slot 0, for slot 1
//   alu_a, alu_b, alu_op    fields of the granted slot, driven to the ALU
//   alu_y                   combinational ALU result
//   res_valid/res_ready     result register handshake toward writeback
//   res_tag                 slot that produced the held result
//   res_data                held result
//   conflict_cnt            (ARB_STATS_EN only) saturating count of granted
//                           cycles in which both slots were requesting
//
// Optional build macro: ARB_STATS_EN
//------------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   // slot 0
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [WIDTH-1:0] s0_a,
   input  logic [WIDTH-1:0] s0_b,
   input  logic [OPW-1:0]   s0_op,
   // slot 1
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic [WIDTH-1:0] s1_a,
   input  logic [WIDTH-1:0] s1_b,
   input  logic [OPW-1:0]   s1_op,
   // shared ALU
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_y,
`ifdef ARB_STATS_EN
   output logic [15:0]      conflict_cnt,
`endif
   // result register / writeback
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_tag,
   output logic [WIDTH-1:0] res_data
);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic             res_valid_q, res_valid_d;
   logic             res_tag_q,   res_tag_d;
   logic [WIDTH-1:0] res_data_q,  res_data_d;
   logic             last_grant_q, last_grant_d;

   //---------------------------------------------------------------------------
   // Grant decision
   //---------------------------------------------------------------------------
   logic w_can_accept;   // register empty, or draining on this edge
   logic w_both;         // both slots requesting
   logic w_gnt;          // some slot is granted (and therefore accepted)
   logic w_sel;          // which slot is granted (only meaningful with w_gnt)

   always_comb begin
      w_can_accept = !res_valid_q || res_ready;
      w_both       = s0_valid && s1_valid;
      // rst_n gating keeps the readys low while reset is asserted, even
      // though the (cleared) register would otherwise allow an accept.
      w_gnt        = rst_n && w_can_accept && (s0_valid || s1_valid);
      // On conflict the slot that did not win last time goes; otherwise
      // the lone requester goes.
      w_sel        = w_both ? ~last_grant_q : s1_valid;
   end

   // A ready is only raised toward a valid slot, so ready implies accept.
   assign s0_ready = w_gnt && !w_sel;
   assign s1_ready = w_gnt &&  w_sel;

   //---------------------------------------------------------------------------
   // ALU operand mux. Slot 0 is the idle default; nothing is captured then.
   //---------------------------------------------------------------------------
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      if (rst_n) begin
         if (w_gnt && w_sel) begin
            alu_a  = s1_a;
            alu_b  = s1_b;
            alu_op = s1_op;
         end else begin
            alu_a  = s0_a;
            alu_b  = s0_b;
            alu_op = s0_op;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Result register next state
   //---------------------------------------------------------------------------
   always_comb begin
      res_valid_d  = res_valid_q;
      res_tag_d    = res_tag_q;
      res_data_d   = res_data_q;
      last_grant_d = last_grant_q;
      if (w_gnt) begin
         // Covers the simultaneous drain+accept case: reload, stay valid.
         res_valid_d  = 1'b1;
         res_tag_d    = w_sel;
         res_data_d   = alu_y;
         last_grant_d = w_sel;
      end else if (res_valid_q && res_ready) begin
         // Plain drain: tag and data keep their last values.
         res_valid_d  = 1'b0;
      end
   end

   // last_grant resets to 1 so that slot 0 wins the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q  <= 1'b0;
         res_tag_q    <= 1'b0;
         res_data_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         res_valid_q  <= res_valid_d;
         res_tag_q    <= res_tag_d;
         res_data_q   <= res_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_tag   = res_tag_q;
   assign res_data  = res_data_q;

`ifdef ARB_STATS_EN
   //---------------------------------------------------------------------------
   // Conflict statistics: saturating count of granted contested cycles
   //---------------------------------------------------------------------------
   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (w_gnt && w_both && (conflict_cnt_q != c_CNT_MAX)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt_q <= 16'd0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire
